// File: rtl/neopixel_pkg.sv
// Shared types and constants for the WS2812 serialiser: state encoding, colour slots, frame geometry, default timing.
// Default timing assumes a 50 MHz clock (1.25 us bit period, 50 us latch gap).
package neopixel_pkg;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t SEND = 2'd1;
  localparam state_t WAIT = 2'd2;

  typedef enum logic [1:0] {
    RED   = 2'd0,
    GREEN = 2'd1,
    BLUE  = 2'd2
  } color_e;

  localparam int NUM_PIXELS     = 5;
  localparam int NUM_COLORS     = 3;
  localparam int BITS_PER_FRAME = NUM_PIXELS * NUM_COLORS * 8;

  localparam int DEF_T0H     = 18;
  localparam int DEF_T1H     = 35;
  localparam int DEF_T_BIT   = 63;
  localparam int DEF_T_RESET = 2500;

endpackage

// File: rtl/neopixel_tx_if.sv
// Producer-side bundle of the serialiser: colour loads, frame request, Moore ready flags, done pulses, data line.
// master = producer (drives load/send), slave = neopixel_tx.
interface neopixel_tx_if;
  logic       load_color;
  logic [2:0] pixel_index;
  logic [1:0] color_index;
  logic [7:0] color_level;
  logic       send_it;
  logic       ready_to_load;
  logic       ready_to_send;
  logic       done_send;
  logic       done_wait;
  logic       neo_data;

  modport master (
    output load_color, pixel_index, color_index, color_level, send_it,
    input  ready_to_load, ready_to_send, done_send, done_wait, neo_data
  );

  modport slave (
    input  load_color, pixel_index, color_index, color_level, send_it,
    output ready_to_load, ready_to_send, done_send, done_wait, neo_data
  );
endinterface

// File: rtl/neopixel_tx_counter.sv
// Up-counter with synchronous clear that wraps to zero after MAX; one-cycle update latency.
// No backpressure: counts whenever en is high and clr is low.
module neopixel_tx_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == MAX_V) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/neopixel_tx.sv
// WS2812 frame serialiser: 5 pixels x GRB bytes MSB first, registered data line, then a T_RESET low latch gap.
// First bit high starts one cycle after send_it; loads and sends are accepted only in IDLE (ready_* high).
module neopixel_tx
  import neopixel_pkg::*;
#(
  parameter int T0H     = DEF_T0H,
  parameter int T1H     = DEF_T1H,
  parameter int T_BIT   = DEF_T_BIT,
  parameter int T_RESET = DEF_T_RESET
) (
  input  logic          clock,
  input  logic          reset_L,
  neopixel_tx_if.slave  bus
);

  localparam int CYC_W  = $clog2(T_BIT + 1);
  localparam int WAIT_W = $clog2(T_RESET + 1);
  localparam int BIT_W  = $clog2(BITS_PER_FRAME);

  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(T_BIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(T_RESET - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS_PER_FRAME - 1);
  localparam logic [CYC_W:0]    T0H_V     = (CYC_W + 1)'(T0H);
  localparam logic [CYC_W:0]    T1H_V     = (CYC_W + 1)'(T1H);

  state_t            state;
  logic              neo_q;
  logic              done_send_q;
  logic              done_wait_q;
  logic [7:0]        color_reg [NUM_PIXELS][NUM_COLORS];
  logic [BITS_PER_FRAME-1:0] frame;
  logic [CYC_W-1:0]  cyc_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              in_send;
  logic              in_wait;
  logic              cyc_last;
  logic              bit_last;
  logic              wait_last;
  logic              cur_bit;
  logic [CYC_W:0]    high_len;
  logic [CYC_W:0]    cyc_nxt;

  assign in_send   = (state == SEND);
  assign in_wait   = (state == WAIT);
  assign cyc_last  = (cyc_cnt == CYC_LAST);
  assign bit_last  = (bit_cnt == BIT_LAST);
  assign wait_last = (wait_cnt == WAIT_LAST);

  neopixel_tx_counter #(.WIDTH(CYC_W), .MAX(T_BIT - 1)) u_cyc_cnt (
    .clock(clock), .reset_L(reset_L), .clr(!in_send), .en(in_send), .count(cyc_cnt)
  );

  // Bit index holds at the last bit; leaving SEND clears it, so it never runs into a second frame.
  neopixel_tx_counter #(.WIDTH(BIT_W), .MAX(BITS_PER_FRAME - 1)) u_bit_cnt (
    .clock(clock), .reset_L(reset_L), .clr(!in_send),
    .en(in_send && cyc_last && !bit_last), .count(bit_cnt)
  );

  neopixel_tx_counter #(.WIDTH(WAIT_W), .MAX(T_RESET - 1)) u_wait_cnt (
    .clock(clock), .reset_L(reset_L), .clr(!in_wait), .en(in_wait), .count(wait_cnt)
  );

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      for (int p = 0; p < NUM_PIXELS; p++)
        for (int c = 0; c < NUM_COLORS; c++)
          color_reg[p][c] <= '0;
    end else if (state == IDLE && bus.load_color) begin
      for (int p = 0; p < NUM_PIXELS; p++)
        for (int c = 0; c < NUM_COLORS; c++)
          if (bus.pixel_index == 3'(p) && bus.color_index == 2'(c))
            color_reg[p][c] <= bus.color_level;
    end
  end

  // Wire order on the line: pixel 0 first, G then R then B, MSB first.
  always_comb begin
    frame = '0;
    for (int p = 0; p < NUM_PIXELS; p++)
      frame[BITS_PER_FRAME-1-24*p -: 24] = {color_reg[p][GREEN], color_reg[p][RED], color_reg[p][BLUE]};
  end

  assign cur_bit  = frame[BIT_LAST - bit_cnt];
  assign high_len = cur_bit ? T1H_V : T0H_V;
  assign cyc_nxt  = {1'b0, cyc_cnt} + 1'b1;

  // neo_q is computed one cycle ahead so the line itself comes straight from a flop.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state       <= IDLE;
      neo_q       <= 1'b0;
      done_send_q <= 1'b0;
      done_wait_q <= 1'b0;
    end else begin
      done_send_q <= 1'b0;
      done_wait_q <= 1'b0;
      case (state)
        IDLE: begin
          neo_q <= bus.send_it;
          if (bus.send_it) state <= SEND;
        end
        SEND: begin
          if (!cyc_last) begin
            neo_q <= (cyc_nxt < high_len);
          end else if (!bit_last) begin
            neo_q <= 1'b1;
          end else begin
            neo_q       <= 1'b0;
            done_send_q <= 1'b1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          neo_q <= 1'b0;
          if (wait_last) begin
            done_wait_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          neo_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready_to_load = (state == IDLE);
  assign bus.ready_to_send = (state == IDLE);
  assign bus.done_send     = done_send_q;
  assign bus.done_wait     = done_wait_q;
  assign bus.neo_data      = neo_q;

endmodule

// File: tb/tb_neopixel_tx.sv
// Directed bench for neopixel_tx with short timing (T0H=2, T1H=4, T_BIT=6, T_RESET=10).
// Each frame is compared sample-by-sample against the waveform implied by a hand-written expected bit vector.
module tb_neopixel_tx;

  localparam int T0H      = 2;
  localparam int T1H      = 4;
  localparam int T_BIT    = 6;
  localparam int T_RESET  = 10;
  localparam int NBITS    = 120;
  localparam int SEND_CYC = NBITS * T_BIT;

  logic clock   = 1'b0;
  logic reset_L = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  neopixel_tx_if bus ();

  neopixel_tx #(.T0H(T0H), .T1H(T1H), .T_BIT(T_BIT), .T_RESET(T_RESET)) dut (
    .clock  (clock),
    .reset_L(reset_L),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]   pix;
    logic [1:0]   col;
    logic [7:0]   lvl;
    bit           coinc;
    logic [119:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    repeat (2) @(negedge clock);
    reset_L = 1'b1;
    @(negedge clock);
  endtask

  task automatic load(input logic [2:0] p, input logic [1:0] c, input logic [7:0] l);
    bus.load_color  = 1'b1;
    bus.pixel_index = p;
    bus.color_index = c;
    bus.color_level = l;
    @(negedge clock);
    bus.load_color  = 1'b0;
  endtask

  // Called at a negedge; send_it is sampled on the next posedge, sample s=0 is the cycle after it.
  task automatic run_frame(input logic [119:0] exp, input bit inject, input string tag);
    int wave_err, rdy_err, ds_at, ds_n, dw_at, dw_n, hi, idx;
    logic [119:0] got;
    logic e;
    wave_err = 0; rdy_err = 0; ds_at = -1; ds_n = 0; dw_at = -1; dw_n = 0; hi = 0;
    got = '0;
    bus.send_it = 1'b1;
    for (int s = 0; s < SEND_CYC + T_RESET + 10; s++) begin
      @(negedge clock);
      e = 1'b0;
      if (s < SEND_CYC) begin
        idx = s / T_BIT;
        if (s % T_BIT == 0) hi = 0;
        if (bus.neo_data === 1'b1) hi++;
        if (s % T_BIT == T_BIT - 1 && hi == T1H) got[idx] = 1'b1;
        e = ((s % T_BIT) < (exp[idx] ? T1H : T0H));
      end
      if (bus.neo_data !== e) wave_err++;
      if (bus.done_send === 1'b1) begin ds_n++; if (ds_at < 0) ds_at = s; end
      if (bus.done_wait === 1'b1) begin dw_n++; if (dw_at < 0) dw_at = s; end
      if (s < SEND_CYC + T_RESET) begin
        if (bus.ready_to_load !== 1'b0 || bus.ready_to_send !== 1'b0) rdy_err++;
      end else begin
        if (bus.ready_to_load !== 1'b1 || bus.ready_to_send !== 1'b1) rdy_err++;
      end
      if (s == 0) begin bus.send_it = 1'b0; bus.load_color = 1'b0; end
      if (inject && s == 100) begin
        bus.load_color = 1'b1; bus.pixel_index = 3'd0; bus.color_index = 2'd1;
        bus.color_level = 8'hFF; bus.send_it = 1'b1;
      end
      if (inject && s == 101) begin bus.load_color = 1'b0; bus.send_it = 1'b0; end
      if (inject && s == SEND_CYC + 5) bus.send_it = 1'b1;
      if (inject && s == SEND_CYC + 6) bus.send_it = 1'b0;
    end
    check({tag, "/frame"}, got, exp);
    check({tag, "/wave_err"}, wave_err, 0);
    check({tag, "/ready_err"}, rdy_err, 0);
    check({tag, "/done_send_at"}, ds_at, SEND_CYC);
    check({tag, "/done_send_n"}, ds_n, 1);
    check({tag, "/done_wait_at"}, dw_at, SEND_CYC + T_RESET);
    check({tag, "/done_wait_n"}, dw_n, 1);
  endtask

  initial begin
    int dn, hn, rn;

    vecs[0] = '{pix: 3'd0, col: 2'd1, lvl: 8'h80, coinc: 1'b0, exp: 120'h1};
    vecs[1] = '{pix: 3'd4, col: 2'd2, lvl: 8'h01, coinc: 1'b0, exp: 120'h1 << 119};
    vecs[2] = '{pix: 3'd5, col: 2'd0, lvl: 8'hFF, coinc: 1'b0, exp: 120'h0};
    vecs[3] = '{pix: 3'd0, col: 2'd3, lvl: 8'hFF, coinc: 1'b0, exp: 120'h0};
    vecs[4] = '{pix: 3'd2, col: 2'd0, lvl: 8'hA5, coinc: 1'b0,
                exp: (120'h1 << 56) | (120'h1 << 58) | (120'h1 << 61) | (120'h1 << 63)};
    vecs[5] = '{pix: 3'd1, col: 2'd1, lvl: 8'hFF, coinc: 1'b1, exp: 120'hFF << 24};
    vecs[6] = '{pix: 3'd3, col: 2'd2, lvl: 8'h0F, coinc: 1'b0, exp: 120'hF << 92};

    bus.load_color = 1'b0; bus.pixel_index = '0; bus.color_index = '0;
    bus.color_level = '0; bus.send_it = 1'b0;

    repeat (3) @(negedge clock);
    check("rst/neo_data", bus.neo_data, 0);
    check("rst/ready_to_load", bus.ready_to_load, 1);
    check("rst/ready_to_send", bus.ready_to_send, 1);
    check("rst/done_send", bus.done_send, 0);
    check("rst/done_wait", bus.done_wait, 0);
    reset_L = 1'b1;
    @(negedge clock);
    check("idle/neo_data", bus.neo_data, 0);

    run_frame(120'h0, 1'b0, "zero");

    for (int i = 0; i < 7; i++) begin
      do_reset();
      if (vecs[i].coinc) begin
        bus.load_color  = 1'b1;
        bus.pixel_index = vecs[i].pix;
        bus.color_index = vecs[i].col;
        bus.color_level = vecs[i].lvl;
      end else begin
        load(vecs[i].pix, vecs[i].col, vecs[i].lvl);
      end
      run_frame(vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
    end

    // Pixel1 red=0x81 -> bits 32 and 39; in-frame loads/sends must not disturb it, and it must persist.
    do_reset();
    load(3'd1, 2'd0, 8'h81);
    run_frame((120'h1 << 32) | (120'h1 << 39), 1'b1, "inject");
    run_frame((120'h1 << 32) | (120'h1 << 39), 1'b0, "persist");

    // Abort at the start of bit 50.
    load(3'd0, 2'd1, 8'hFF);
    bus.send_it = 1'b1;
    @(negedge clock);
    bus.send_it = 1'b0;
    repeat (300) @(negedge clock);
    check("abort/pre_neo", bus.neo_data, 1);
    reset_L = 1'b0;
    #1;
    check("abort/neo_async", bus.neo_data, 0);
    check("abort/ready_async", bus.ready_to_send, 1);
    dn = 0; hn = 0; rn = 0;
    repeat (3) @(negedge clock);
    reset_L = 1'b1;
    for (int s = 0; s < SEND_CYC + 40; s++) begin
      @(negedge clock);
      if (bus.done_send !== 1'b0 || bus.done_wait !== 1'b0) dn++;
      if (bus.neo_data !== 1'b0) hn++;
      if (bus.ready_to_load !== 1'b1 || bus.ready_to_send !== 1'b1) rn++;
    end
    check("abort/done_pulses", dn, 0);
    check("abort/neo_highs", hn, 0);
    check("abort/not_idle", rn, 0);
    run_frame(120'h0, 1'b0, "after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
